// File: rtl/dfi_rw_sequencer.sv
// Closed-page DFI sequencer: one single-burst read or write at a time,
// issued as ACT -> RD/WR -> PRE with programmable tRCD/tWR/tRP and a read timeout.
module dfi_rw_sequencer #(
  parameter int NUM_AD     = 13,
  parameter int NUM_BA     = 2,
  parameter int NUM_COL    = 10,
  parameter int NUM_D      = 64,
  parameter int TRCD       = 2,
  parameter int TWR        = 2,
  parameter int TRP        = 2,
  parameter int RD_TIMEOUT = 15
) (
  input  logic                             sys_clk,
  input  logic                             sys_rst_n,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_we,
  input  logic [NUM_BA+NUM_AD+NUM_COL-1:0] req_addr,
  input  logic [2*NUM_D-1:0]               req_wdata,
  input  logic [2*NUM_D/8-1:0]             req_wmask,
  output logic                             rsp_valid,
  output logic [2*NUM_D-1:0]               rsp_rdata,
  output logic                             rsp_err,
  output logic [NUM_AD-1:0]                dfi_address_p0,
  output logic [NUM_AD-1:0]                dfi_address_p1,
  output logic [NUM_BA-1:0]                dfi_bank_p0,
  output logic [NUM_BA-1:0]                dfi_bank_p1,
  output logic                             dfi_cs_n_p0,
  output logic                             dfi_cs_n_p1,
  output logic                             dfi_ras_n_p0,
  output logic                             dfi_ras_n_p1,
  output logic                             dfi_cas_n_p0,
  output logic                             dfi_cas_n_p1,
  output logic                             dfi_we_n_p0,
  output logic                             dfi_we_n_p1,
  output logic                             dfi_wrdata_en_p0,
  output logic                             dfi_wrdata_en_p1,
  output logic                             dfi_rddata_en_p0,
  output logic                             dfi_rddata_en_p1,
  output logic [NUM_D-1:0]                 dfi_wrdata_p0,
  output logic [NUM_D-1:0]                 dfi_wrdata_p1,
  output logic [NUM_D/8-1:0]               dfi_wrdata_mask_p0,
  output logic [NUM_D/8-1:0]               dfi_wrdata_mask_p1,
  input  logic [NUM_D-1:0]                 dfi_rddata_w0,
  input  logic [NUM_D-1:0]                 dfi_rddata_w1,
  input  logic                             dfi_rddata_valid_w0,
  input  logic                             dfi_rddata_valid_w1
);
  localparam int AW      = NUM_BA + NUM_AD + NUM_COL;
  localparam int MW      = NUM_D / 8;
  localparam int MAX_A   = (TRCD > TWR) ? TRCD : TWR;
  localparam int MAX_B   = (TRP > RD_TIMEOUT + 1) ? TRP : RD_TIMEOUT + 1;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = $clog2(CNT_MAX + 1);

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] C_DES = 4'b1111;
  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010;

  typedef enum logic [3:0] {IDLE, ACT, RCD, CMD, WDATA, WR, RDWAIT, PRE, RP} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [2*NUM_D-1:0]    wdata_q, wdata_d;
  logic [2*MW-1:0]       wmask_q, wmask_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [2*NUM_D-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic [3:0]            cmd_p0_q, cmd_p0_d, cmd_p1_q, cmd_p1_d;
  logic [NUM_AD-1:0]     address_p0_q, address_p0_d, address_p1_q, address_p1_d;
  logic [NUM_BA-1:0]     bank_p0_q, bank_p0_d, bank_p1_q, bank_p1_d;
  logic                  wrdata_en_q, wrdata_en_d;
  logic                  rddata_en_q, rddata_en_d;
  logic [2*NUM_D-1:0]    wrdata_q, wrdata_d;
  logic [2*MW-1:0]       wrmask_q, wrmask_d;

  logic [NUM_BA-1:0]     bank_w;
  logic [NUM_AD-1:0]     row_w;
  logic [NUM_AD-1:0]     col_w;
  logic                  rd_hit;

  assign bank_w = addr_q[AW-1 -: NUM_BA];
  assign row_w  = addr_q[NUM_COL +: NUM_AD];
  // Column zero-extended; NUM_COL <= 10 keeps A10 (auto-precharge) clear.
  assign col_w  = NUM_AD'(addr_q[NUM_COL-1:0]);
  // The first two RDWAIT cycles precede any possible PHY return and are ignored.
  assign rd_hit = dfi_rddata_valid_w0 && dfi_rddata_valid_w1 && (cnt_q < CW'(RD_TIMEOUT));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    rsp_valid_d  = 1'b0;
    rsp_err_d    = 1'b0;
    rsp_rdata_d  = rsp_rdata_q;
    cmd_p0_d     = C_NOP;
    cmd_p1_d     = C_NOP;
    address_p0_d = '0;
    address_p1_d = '0;
    bank_p0_d    = '0;
    bank_p1_d    = '0;
    wrdata_en_d  = 1'b0;
    rddata_en_d  = 1'b0;
    wrdata_d     = '0;
    wrmask_d     = '0;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wmask_d = req_wmask;
          state_d = ACT;
        end
      end
      ACT: begin
        cmd_p0_d     = C_ACT;
        address_p0_d = row_w;
        bank_p0_d    = bank_w;
        if (TRCD == 1) begin
          state_d = CMD;
        end else begin
          state_d = RCD;
          cnt_d   = CW'(TRCD - 2);
        end
      end
      RCD: begin
        if (cnt_q == '0) state_d = CMD;
        else             cnt_d   = cnt_q - CW'(1);
      end
      CMD: begin
        if (we_q) begin
          cmd_p1_d     = C_WR;
          address_p1_d = col_w;
          bank_p1_d    = bank_w;
          state_d      = WDATA;
        end else begin
          cmd_p0_d     = C_RD;
          address_p0_d = col_w;
          bank_p0_d    = bank_w;
          state_d      = RDWAIT;
          cnt_d        = CW'(RD_TIMEOUT + 1);
        end
      end
      WDATA: begin
        wrdata_en_d = 1'b1;
        wrdata_d    = wdata_q;
        wrmask_d    = wmask_q;
        if (TWR == 1) begin
          state_d = PRE;
        end else begin
          state_d = WR;
          cnt_d   = CW'(TWR - 2);
        end
      end
      WR: begin
        if (cnt_q == '0) state_d = PRE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      RDWAIT: begin
        rddata_en_d = (cnt_q == CW'(RD_TIMEOUT + 1));
        // Precharge goes out alongside the response, so skip the PRE state.
        if (rd_hit || cnt_q == '0) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = !rd_hit;
          rsp_rdata_d = rd_hit ? {dfi_rddata_w1, dfi_rddata_w0} : '0;
          cmd_p0_d    = C_PRE;
          bank_p0_d   = bank_w;
          state_d     = RP;
          cnt_d       = CW'(TRP - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      PRE: begin
        cmd_p0_d  = C_PRE;
        bank_p0_d = bank_w;
        state_d   = RP;
        cnt_d     = CW'(TRP - 1);
      end
      RP: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      req_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_rdata_q  <= '0;
      cmd_p0_q     <= C_DES;
      cmd_p1_q     <= C_DES;
      address_p0_q <= '0;
      address_p1_q <= '0;
      bank_p0_q    <= '0;
      bank_p1_q    <= '0;
      wrdata_en_q  <= 1'b0;
      rddata_en_q  <= 1'b0;
      wrdata_q     <= '0;
      wrmask_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      rsp_rdata_q  <= rsp_rdata_d;
      cmd_p0_q     <= cmd_p0_d;
      cmd_p1_q     <= cmd_p1_d;
      address_p0_q <= address_p0_d;
      address_p1_q <= address_p1_d;
      bank_p0_q    <= bank_p0_d;
      bank_p1_q    <= bank_p1_d;
      wrdata_en_q  <= wrdata_en_d;
      rddata_en_q  <= rddata_en_d;
      wrdata_q     <= wrdata_d;
      wrmask_q     <= wrmask_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign {dfi_cs_n_p0, dfi_ras_n_p0, dfi_cas_n_p0, dfi_we_n_p0} = cmd_p0_q;
  assign {dfi_cs_n_p1, dfi_ras_n_p1, dfi_cas_n_p1, dfi_we_n_p1} = cmd_p1_q;
  assign dfi_address_p0     = address_p0_q;
  assign dfi_address_p1     = address_p1_q;
  assign dfi_bank_p0        = bank_p0_q;
  assign dfi_bank_p1        = bank_p1_q;
  assign dfi_wrdata_en_p0   = 1'b0;
  assign dfi_wrdata_en_p1   = wrdata_en_q;
  assign dfi_rddata_en_p0   = rddata_en_q;
  assign dfi_rddata_en_p1   = 1'b0;
  assign dfi_wrdata_p0      = wrdata_q[NUM_D-1:0];
  assign dfi_wrdata_p1      = wrdata_q[2*NUM_D-1:NUM_D];
  assign dfi_wrdata_mask_p0 = wrmask_q[MW-1:0];
  assign dfi_wrdata_mask_p1 = wrmask_q[2*MW-1:MW];
endmodule

// File: tb/tb_dfi_rw_sequencer.sv
// Bench for dfi_rw_sequencer: a request-level model predicts the timed event
// stream (commands, data, response, ready) and a monitor checks the DUT against it.
module tb_dfi_rw_sequencer;
  localparam int NUM_AD = 13, NUM_BA = 2, NUM_COL = 10, NUM_D = 64;
  localparam int TRCD = 2, TWR = 2, TRP = 2, RD_TIMEOUT = 15;
  localparam int K_PRE = 2, K_ACT = 3, K_RD = 5, K_WR = 16 + 4;
  localparam int K_WDATA = 100, K_RDEN = 101, K_RSP = 102, K_RDY = 103;

  typedef struct {
    int           cyc;
    int           kind;
    logic [127:0] d;
    logic [15:0]  m;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid, req_ready, req_we;
  logic [24:0] req_addr;
  logic [127:0] req_wdata;
  logic [15:0] req_wmask;
  logic rsp_valid, rsp_err;
  logic [127:0] rsp_rdata;
  logic [12:0] addr_p0, addr_p1;
  logic [1:0] bank_p0, bank_p1;
  logic cs_p0, cs_p1, ras_p0, ras_p1, cas_p0, cas_p1, we_p0, we_p1;
  logic wen_p0, wen_p1, ren_p0, ren_p1;
  logic [63:0] wd_p0, wd_p1, rd_w0, rd_w1;
  logic [7:0] wm_p0, wm_p1;
  logic rv_w0, rv_w1;

  int tests = 0, fails = 0, cyc = 0;
  ev_t expq[$];
  bit mon_en = 0, prev_ready = 0, cur_read = 0;
  int cur_h = 0, cur_wend = 0, rd_v_cyc = -1;
  logic [127:0] rd_val = '0;

  dfi_rw_sequencer #(.NUM_AD(NUM_AD), .NUM_BA(NUM_BA), .NUM_COL(NUM_COL), .NUM_D(NUM_D),
                     .TRCD(TRCD), .TWR(TWR), .TRP(TRP), .RD_TIMEOUT(RD_TIMEOUT)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .dfi_address_p0(addr_p0), .dfi_address_p1(addr_p1), .dfi_bank_p0(bank_p0), .dfi_bank_p1(bank_p1),
    .dfi_cs_n_p0(cs_p0), .dfi_cs_n_p1(cs_p1), .dfi_ras_n_p0(ras_p0), .dfi_ras_n_p1(ras_p1),
    .dfi_cas_n_p0(cas_p0), .dfi_cas_n_p1(cas_p1), .dfi_we_n_p0(we_p0), .dfi_we_n_p1(we_p1),
    .dfi_wrdata_en_p0(wen_p0), .dfi_wrdata_en_p1(wen_p1),
    .dfi_rddata_en_p0(ren_p0), .dfi_rddata_en_p1(ren_p1),
    .dfi_wrdata_p0(wd_p0), .dfi_wrdata_p1(wd_p1),
    .dfi_wrdata_mask_p0(wm_p0), .dfi_wrdata_mask_p1(wm_p1),
    .dfi_rddata_w0(rd_w0), .dfi_rddata_w1(rd_w1),
    .dfi_rddata_valid_w0(rv_w0), .dfi_rddata_valid_w1(rv_w1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] cmd_fields(input logic [1:0] b, input logic [12:0] a);
    logic [127:0] r;
    r = '0;
    r[12:0] = a;
    r[17:16] = b;
    return r;
  endfunction

  task automatic push_ev(input int c, input int k, input logic [127:0] d, input logic [15:0] m);
    ev_t e;
    e.cyc = c; e.kind = k; e.d = d; e.m = m;
    expq.push_back(e);
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    $display("[TB] reset check (%s)", tag);
    chk({tag, "_ready"}, 256'(req_ready), 256'(0));
    chk({tag, "_rsp"}, 256'({rsp_valid, rsp_err, rsp_rdata}), 256'(0));
    chk({tag, "_cmd"}, 256'({cs_p0, ras_p0, cas_p0, we_p0, cs_p1, ras_p1, cas_p1, we_p1}), 256'(8'hff));
    chk({tag, "_addr"}, 256'({addr_p0, addr_p1, bank_p0, bank_p1}), 256'(0));
    chk({tag, "_data"}, 256'({wen_p0, wen_p1, ren_p0, ren_p1, wd_p0, wd_p1, wm_p0, wm_p1}), 256'(0));
  endtask

  task automatic obs(input int k, input logic [127:0] d, input logic [15:0] m);
    ev_t e;
    tests++;
    if (expq.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event: got cyc=%0d kind=%0d d=%h m=%h, required no event", cyc, k, d, m);
    end else begin
      e = expq.pop_front();
      if (e.cyc != cyc || e.kind != k || e.d !== d || e.m !== m) begin
        fails++;
        $display("FAIL event: got cyc=%0d kind=%0d d=%h m=%h, required cyc=%0d kind=%0d d=%h m=%h",
                 cyc, k, d, m, e.cyc, e.kind, e.d, e.m);
      end
    end
  endtask

  // Monitor: every DUT event is popped against the model's expected stream.
  initial forever begin
    logic [3:0] c0, c1;
    bit bad;
    @(negedge clk);
    if (mon_en) begin
      c0 = {cs_p0, ras_p0, cas_p0, we_p0};
      c1 = {cs_p1, ras_p1, cas_p1, we_p1};
      bad = 1'b0;
      if (c0 != 4'b0111) obs(int'(c0), cmd_fields(bank_p0, addr_p0), 16'h0);
      else if (addr_p0 != 0 || bank_p0 != 0) bad = 1'b1;
      if (c1 != 4'b0111) obs(16 + int'(c1), cmd_fields(bank_p1, addr_p1), 16'h0);
      else if (addr_p1 != 0 || bank_p1 != 0) bad = 1'b1;
      if (wen_p1) obs(K_WDATA, {wd_p1, wd_p0}, {wm_p1, wm_p0});
      else if (wd_p0 != 0 || wd_p1 != 0 || wm_p0 != 0 || wm_p1 != 0) bad = 1'b1;
      if (wen_p0 || ren_p1) bad = 1'b1;
      if (ren_p0) obs(K_RDEN, '0, 16'h0);
      if (rsp_valid) obs(K_RSP, rsp_rdata, {15'h0, rsp_err});
      if (req_ready && !prev_ready) obs(K_RDY, '0, 16'h0);
      prev_ready = req_ready;
      tests++;
      if (bad) begin
        fails++;
        $display("FAIL idle_fields cyc=%0d: got a0=%h b0=%h a1=%h b1=%h wen0=%b ren1=%b wd=%h%h wm=%h%h, required zero",
                 cyc, addr_p0, bank_p0, addr_p1, bank_p1, wen_p0, ren_p1, wd_p1, wd_p0, wm_p1, wm_p0);
      end
    end
  end

  // PHY read-return driver: real burst at rd_v_cyc, random strays elsewhere
  // (only partial valids inside an open read window).
  initial forever begin
    int r;
    @(negedge clk);
    rd_w0 = {$urandom, $urandom};
    rd_w1 = {$urandom, $urandom};
    r = $urandom_range(0, 3);
    rv_w0 = 1'b0;
    rv_w1 = 1'b0;
    if (cyc == rd_v_cyc) begin
      rv_w0 = 1'b1; rv_w1 = 1'b1;
      rd_w0 = rd_val[63:0]; rd_w1 = rd_val[127:64];
    end else if (!cur_read || cyc < cur_h + 3 + TRCD || cyc > cur_wend) begin
      rv_w0 = r[0]; rv_w1 = r[1];
    end else if (r == 1) begin
      rv_w0 = 1'b1;
    end else if (r == 2) begin
      rv_w1 = 1'b1;
    end
  end

  // Present a request, wait for acceptance, and predict its full event stream.
  // voff < 0 means the PHY never returns data (timeout).
  task automatic issue(input bit we, input logic [1:0] b, input logic [12:0] row, input logic [9:0] col,
                       input logic [127:0] wd, input logic [15:0] wm, input int voff,
                       input logic [127:0] rd, input bit hold);
    int h, e, i;
    req_valid = 1'b1; req_we = we; req_addr = {b, row, col}; req_wdata = wd; req_wmask = wm;
    i = 0;
    while (!req_ready && i < 200) begin
      @(negedge clk);
      i++;
    end
    if (!req_ready) begin
      tests++; fails++;
      $display("FAIL accept_timeout: got req_ready=0 for 200 cycles, required 1");
      req_valid = 1'b0;
      return;
    end
    h = cyc + 1;
    push_ev(h + 1, K_ACT, cmd_fields(b, row), 16'h0);
    if (we) begin
      cur_read = 1'b0;
      push_ev(h + 1 + TRCD, K_WR, cmd_fields(b, 13'(col)), 16'h0);
      push_ev(h + 2 + TRCD, K_WDATA, wd, wm);
      push_ev(h + 2 + TRCD + TWR, K_PRE, cmd_fields(b, 13'h0), 16'h0);
      push_ev(h + 2 + TRCD + TWR + TRP, K_RDY, '0, 16'h0);
    end else begin
      push_ev(h + 1 + TRCD, K_RD, cmd_fields(b, 13'(col)), 16'h0);
      push_ev(h + 2 + TRCD, K_RDEN, '0, 16'h0);
      if (voff < 0) begin
        rd_v_cyc = -1;
        e = h + 3 + TRCD + RD_TIMEOUT;
        cur_wend = e - 1;
      end else begin
        rd_v_cyc = h + voff;
        rd_val = rd;
        e = h + voff + 1;
        cur_wend = h + voff;
      end
      cur_h = h;
      cur_read = 1'b1;
      push_ev(e, K_PRE, cmd_fields(b, 13'h0), 16'h0);
      push_ev(e, K_RSP, (voff < 0) ? 128'h0 : rd, (voff < 0) ? 16'h1 : 16'h0);
      push_ev(e + TRP, K_RDY, '0, 16'h0);
    end
    $display("[TB] txn %s bank=%0d row=%h col=%h accepted at cyc %0d voff=%0d", we ? "WR" : "RD", b, row, col, h, voff);
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
  endtask

  initial begin
    bit we, hold;
    int voff, n;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;
    repeat (3) @(negedge clk);
    check_reset("por");
    rst_n = 1'b1;
    #1 chk("ready_before_edge", 256'(req_ready), 256'(0));
    @(negedge clk);
    chk("ready_after_release", 256'(req_ready), 256'(1));
    prev_ready = 1'b1;
    mon_en = 1'b1;

    issue(1'b1, 2'd1, 13'h0dbe, 10'h055, {64'h0123456789abcdef, 64'hcafebabeabadface}, 16'h3412, 0, '0, 1'b0);
    issue(1'b0, 2'd0, 13'h1234, 10'h2a5, '0, 16'h0, 7, {64'habadfacecafebabe, 64'hdeadbeef12345678}, 1'b0);
    issue(1'b0, 2'd3, 13'h0abc, 10'h3ff, '0, 16'h0, -1, '0, 1'b0);
    issue(1'b1, 2'd2, 13'h1fff, 10'h000, {4{32'h5a5a0f0f}}, 16'hffff, 0, '0, 1'b1);
    issue(1'b1, 2'd0, 13'h0001, 10'h3ff, {4{32'h13579bdf}}, 16'h00ff, 0, '0, 1'b0);
    issue(1'b0, 2'd1, 13'h0f0f, 10'h111, '0, 16'h0, 2 + TRCD + RD_TIMEOUT, {4{32'h89abcdef}}, 1'b0);

    // Reset in cycle 4 of a write: the pending PRE and ready edge are dropped.
    issue(1'b1, 2'd3, 13'h0777, 10'h0aa, {4{32'hfeedf00d}}, 16'hf0f0, 0, '0, 1'b0);
    repeat (4) @(negedge clk);
    #2;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1 check_reset("mid_write");
    expq.delete();
    cur_read = 1'b0;
    rd_v_cyc = -1;
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ready_before_edge2", 256'(req_ready), 256'(0));
    @(negedge clk);
    chk("ready_after_release2", 256'(req_ready), 256'(1));
    prev_ready = 1'b1;
    mon_en = 1'b1;

    hold = 1'b0;
    for (int t = 0; t < 30; t++) begin
      if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
      we = 1'($urandom_range(0, 1));
      hold = (t != 29) && ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) voff = -1;
      else voff = $urandom_range(3 + TRCD, 2 + TRCD + RD_TIMEOUT);
      issue(we, 2'($urandom), 13'($urandom), 10'($urandom),
            {$urandom, $urandom, $urandom, $urandom}, 16'($urandom), voff,
            {$urandom, $urandom, $urandom, $urandom}, hold);
    end

    n = 0;
    while (expq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("drain_expected_queue", 256'(expq.size()), 256'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500000 time units, required finish");
    $fatal(1, "watchdog expired");
  end
endmodule
